// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// Multi-cycle RV32M multiply/divide sequencer: one shared shift-add / restoring-divide engine,
// iterating on operand magnitudes with a final sign-fix cycle.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            start,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LastCnt = CW'(XLEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Decode of the incoming request (op index 0..7 = mul..remu)
  logic            valid_op, in_div, in_rem, in_sdiv, a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [2:0]      op_in;
  logic [XLEN-1:0] a_mag, b_mag, special_val;

  always_comb begin
    valid_op = (aluControl >= 5'h0A) && (aluControl <= 5'h11);
    op_in    = 3'(aluControl - 5'h0A);
    in_div   = op_in[2];
    in_rem   = op_in[2] & op_in[1];
    in_sdiv  = op_in[2] & ~op_in[0];
    a_sgn    = op_in[2] ? ~op_in[0] : (op_in != 3'd3);
    b_sgn    = op_in[2] ? ~op_in[0] : ~op_in[1];
    a_neg    = a_sgn & srcA[XLEN-1];
    b_neg    = b_sgn & srcB[XLEN-1];
    a_mag    = a_neg ? -srcA : srcA;
    b_mag    = b_neg ? -srcB : srcB;
    div0     = in_div && (srcB == '0);
    ovf      = in_sdiv && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
    if (div0) special_val = in_rem ? srcA : '1;
    else      special_val = in_rem ? '0 : srcA;
  end

  // One iteration of the engine; acc holds {hi, lo}
  logic [XLEN:0]     mul_sum, rem_sh, rem_dif;
  logic              q_bit;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_dif  = rem_sh - {1'b0, opnd_q};
    q_bit    = ~rem_dif[XLEN];
    div_next = {(q_bit ? rem_dif[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
    prod_fix = neg_q ? -acc_q : acc_q;
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:                fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_res = neg_q ? -quo : quo;
      default:             fix_res = neg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;
    case (state_q)
      StIdle: begin
        if (start && valid_op && !flush) begin
          state_d   = StRun;
          cnt_d     = '0;
          op_d      = op_in;
          special_d = div0 | ovf;
          neg_d     = in_rem ? a_neg : (a_neg ^ b_neg);
          // Divide keeps the dividend in lo; multiply keeps the multiplier in lo
          acc_d     = {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
          opnd_d    = in_div ? b_mag : a_mag;
          if (div0 | ovf) acc_d = {{XLEN{1'b0}}, special_val};
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else if (special_q) begin
          result_d = acc_q[XLEN-1:0];
          state_d  = StDone;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastCnt) state_d = StFix;
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_res;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == StRun) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
// Directed self-checking bench for muldiv_sequencer: latency, results, special cases,
// flush, mid-op reset and ignored requests.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [4:0]  aluControl;
  logic [31:0] srcA, srcB;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .aluControl (aluControl),
    .srcA       (srcA),
    .srcB       (srcB),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; hold=1 keeps start high and disturbs srcA mid-op
  task automatic run_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold);
    int cyc;
    int bc;
    aluControl = code;
    srcA       = a;
    srcB       = b;
    start      = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    cyc = 1;
    bc  = 0;
    while (!done && cyc < 60) begin
      if (busy) bc++;
      if (hold && cyc == 3) srcA = ~a;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "_busy_cycles"}, bc, lat - 1);
    tick();
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int dcount;
    resetN     = 1'b0;
    start      = 1'b0;
    aluControl = 5'h00;
    srcA       = '0;
    srcB       = '0;
    flush      = 1'b0;
    tick();
    tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    resetN = 1'b1;
    tick();

    // T1 / T2 multiplies
    run_op("mul_7x6",    5'h0A, 32'd7,        32'd6,        32'd42,       34, 1'b0);
    run_op("mul_neg",    5'h0A, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34, 1'b0);
    run_op("mulh_min",   5'h0B, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
    run_op("mulhu_max",  5'h0E - 5'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
    run_op("mulhsu",     5'h0C, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1'b0);

    // T3 divides
    run_op("div_m7_2",   5'h0E, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_m7_2",   5'h10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
    run_op("divu_100_7", 5'h0F, 32'd100,      32'd7,        32'd14,       34, 1'b0);
    run_op("remu_100_7", 5'h11, 32'd100,      32'd7,        32'd2,        34, 1'b0);
    run_op("div_7_m2",   5'h0E, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_7_m2",   5'h10, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 1'b0);

    // T4 special cases
    run_op("div_by0",    5'h0E, 32'd5,        32'd0,        32'hFFFFFFFF, 2, 1'b0);
    run_op("rem_by0",    5'h10, 32'd5,        32'd0,        32'd5,        2, 1'b0);
    run_op("divu_by0",   5'h0F, 32'd5,        32'd0,        32'hFFFFFFFF, 2, 1'b0);
    run_op("div_ovf",    5'h0E, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
    run_op("rem_ovf",    5'h10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2, 1'b0);

    // T5 flush at RUN cycle 10
    run_op("pre_flush",  5'h0A, 32'd7,        32'd6,        32'd42,       34, 1'b0);
    aluControl = 5'h0F;
    srcA       = 32'd100;
    srcB       = 32'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_result", result, 32'd42);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("flush_no_activity", dcount, 32'd0);
    run_op("post_flush", 5'h11, 32'd100,      32'd7,        32'd2,        34, 1'b0);

    // flush and start together in IDLE: flush wins
    aluControl = 5'h0A;
    srcA       = 32'd3;
    srcB       = 32'd3;
    start      = 1'b1;
    flush      = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_idle", {31'b0, busy}, 32'd0);

    // T6 reset mid-run
    aluControl = 5'h0A;
    srcA       = 32'd9;
    srcB       = 32'd9;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    resetN = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_done", {31'b0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    #2;
    resetN = 1'b1;
    tick();

    // start held through the op with srcA disturbed: operands must not be re-sampled
    run_op("held_start", 5'h0A, 32'd7,        32'd6,        32'd42,       34, 1'b1);

    // invalid code ignored
    aluControl = 5'h04;
    srcA       = 32'd7;
    srcB       = 32'd6;
    start      = 1'b1;
    tick();
    chk("bad_code_busy1", {31'b0, busy}, 32'd0);
    tick();
    start = 1'b0;
    chk("bad_code_busy2", {31'b0, busy}, 32'd0);
    chk("bad_code_done", {31'b0, done}, 32'd0);
    chk("bad_code_result", result, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
